// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared definitions for the Newton-Raphson square-root datapath.
// Holds the sequencer state codes (also decoded by the datapath control
// decoder), the ALU operation codes and the register-file addresses.
package sqrt_pkg;

  // Sequencer state codes; codes 1011..1111 are unused and recover to S0.
  typedef enum logic [3:0] {
    S0  = 4'b0000,  // idle
    S1  = 4'b0001,  // load n
    S2  = 4'b0010,  // x = n
    S3  = 4'b0011,  // root = n / x
    S4  = 4'b0100,  // root += x
    S5  = 4'b0101,  // root /= 2
    S6  = 4'b0110,  // temp = root - x
    S7  = 4'b0111,  // temp = |temp|
    S8  = 4'b1000,  // temp = temp - I
    S9  = 4'b1001,  // x = root
    S10 = 4'b1010   // output
  } state_e;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_DIV = 2'b10;
  localparam logic [1:0] ALU_ABS = 2'b11;

  // Register-file addresses
  localparam logic [2:0] REG_N      = 3'b001;
  localparam logic [2:0] REG_X      = 3'b010;
  localparam logic [2:0] REG_ROOT   = 3'b011;
  localparam logic [2:0] REG_TEMP   = 3'b100;
  localparam logic [2:0] REG_CONST2 = 3'b101;
  localparam logic [2:0] REG_I      = 3'b110;

endpackage

// File: rtl/sqrt_sequencer_iter_counter.sv
// iter_counter: iteration counter and timeout flag for the sqrt sequencer.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   clear        - start of run: count and timeout go to zero
//   incr         - one S8 visit completed
//   timeout_set  - exit was forced by the iteration limit
//   count        - completed iterations of the current run
//   timeout      - latched forced-exit flag
//   last         - the pending increment reaches MAX_ITER
module iter_counter #(
  parameter int MAX_ITER = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incr,
  input  logic             timeout_set,
  output logic [CNT_W-1:0] count,
  output logic             timeout,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MAX_ITER - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] count_d, count_q;
  logic             timeout_d, timeout_q;

  // Next count / timeout: clear wins, otherwise increment and latch the flag
  always_comb begin
    count_d   = count_q;
    timeout_d = timeout_q;
    if (clear) begin
      count_d   = '0;
      timeout_d = 1'b0;
    end else begin
      if (incr) begin
        count_d = count_q + ONE;
      end else begin
        count_d = count_q;
      end
      if (timeout_set) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
    end
  end

  // Counter and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  // Count + 1 == MAX_ITER, so the S8 exit can never overflow the counter
  assign last    = (count_q == LAST_VAL);
  assign count   = count_q;
  assign timeout = timeout_q;

endmodule

// File: rtl/sqrt_sequencer.sv
// sqrt_sequencer: state generator for the Newton-Raphson square-root datapath.
// Ports:
//   Clk, Reset     - clock, synchronous active-high reset
//   Start          - host request (S0 only)
//   Div_Ready      - divider result valid (S3/S5 only)
//   Alu_Neg        - sign of temp - I (S8 only); 1 means converged
//   Ack            - host has taken the result (S10 only)
//   Current_State  - 4-bit state code to the control decoder
//   Busy, Done     - decoded from the state register
//   Timeout        - latched, exit forced by MAX_ITER
//   Iter_Count     - S8 visits of the current run
// All outputs come straight from registers, so no input reaches an output
// combinationally.
module sqrt_sequencer
  import sqrt_pkg::*;
#(
  parameter int MAX_ITER = 16,
  parameter int CNT_W    = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Div_Ready,
  input  logic             Alu_Neg,
  input  logic             Ack,
  output logic [3:0]       Current_State,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] Iter_Count
);

  state_e state_d, state_q;
  logic   cnt_clear_s;
  logic   cnt_incr_s;
  logic   cnt_timeout_s;
  logic   cnt_last_s;

  iter_counter #(
    .MAX_ITER (MAX_ITER),
    .CNT_W    (CNT_W)
  ) u_iter_counter (
    .clk         (Clk),
    .reset       (Reset),
    .clear       (cnt_clear_s),
    .incr        (cnt_incr_s),
    .timeout_set (cnt_timeout_s),
    .count       (Iter_Count),
    .timeout     (Timeout),
    .last        (cnt_last_s)
  );

  // Next-state and counter-control decode
  always_comb begin
    state_d       = state_q;
    cnt_clear_s   = 1'b0;
    cnt_incr_s    = 1'b0;
    cnt_timeout_s = 1'b0;
    case (state_q)
      S0: begin
        if (Start) state_d = S1;
        else       state_d = S0;
      end
      S1: state_d = S2;
      S2: begin
        state_d     = S3;
        cnt_clear_s = 1'b1;
      end
      // Divider stall: stay put (the write strobe keeps firing) and leave on
      // the edge that sees Div_Ready, so the final write has a valid quotient.
      S3: begin
        if (Div_Ready) state_d = S4;
        else           state_d = S3;
      end
      S4: state_d = S5;
      S5: begin
        if (Div_Ready) state_d = S6;
        else           state_d = S5;
      end
      S6: state_d = S7;
      S7: state_d = S8;
      // Every S8 visit counts, whether the run continues or exits.
      S8: begin
        cnt_incr_s = 1'b1;
        if (Alu_Neg) begin
          state_d = S10;
        end else if (cnt_last_s) begin
          state_d       = S10;
          cnt_timeout_s = 1'b1;
        end else begin
          state_d = S9;
        end
      end
      S9: state_d = S3;
      // Start is ignored here even alongside Ack; the host must re-request.
      S10: begin
        if (Ack) state_d = S0;
        else     state_d = S10;
      end
      default: state_d = S0;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign Current_State = state_q;
  assign Busy          = (state_q != S0);
  assign Done          = (state_q == S10);

endmodule

// File: doc/sqrt_sequencer.md
# sqrt_sequencer

- Sequential state generator for the Newton-Raphson square-root datapath.
- Drives the 4-bit `Current_State` bus that the datapath control decoder turns into register-file, ALU and I/O strobes.
- Decides iteration exit from the ALU sign status, stalls on a multi-cycle divider, bounds iteration count, and handshakes start/done with the host.

## Interface
Parameters:
- `MAX_ITER`, default 16: maximum Newton iterations (S3..S8 passes) before a forced exit; legal range 1..255.
- `CNT_W`, default 8: width of the iteration counter; must hold `MAX_ITER`.

Ports:
- `Clk`  input  1  system clock, rising edge.
- `Reset`  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `Start`  input  1  host request; sampled only in S0.
- `Div_Ready`  input  1  divider result valid; sampled only in S3 and S5.
- `Alu_Neg`  input  1  sign bit of the ALU result (`temp - I`); sampled only in S8.
- `Ack`  input  1  host has taken the output; sampled only in S10.
- `Current_State`  output  4  state code to the control decoder.
- `Busy`  output  1  high in every state except S0.
- `Done`  output  1  high while in S10.
- `Timeout`  output  1  latched; set when exit was forced by `MAX_ITER`.
- `Iter_Count`  output  CNT_W  completed iterations of the current run.

## Operation
State codes: S0=0000 idle, S1=0001 load n, S2=0010 x=n, S3=0011 root=n/x, S4=0100 root+=x, S5=0101 root/=2, S6=0110 temp=root-x, S7=0111 temp=|temp|, S8=1000 temp=temp-I, S9=1001 x=root, S10=1010 output.

Transitions:
- S0 → S1 when `Start`=1; otherwise stay in S0.
- S1 → S2 unconditionally.
- S2 → S3. In S2, `Iter_Count` is cleared to 0 and `Timeout` is cleared.
- S3 → S4 when `Div_Ready`=1; otherwise stay in S3.
- S4 → S5 unconditionally.
- S5 → S6 when `Div_Ready`=1; otherwise stay in S5.
- S6 → S7 → S8 unconditionally.
- S8 with `Alu_Neg`=1 (|root−x| < I, converged) → S10.
- S8 with `Alu_Neg`=0 and `Iter_Count`+1 < `MAX_ITER` → S9, and `Iter_Count` increments.
- S8 with `Alu_Neg`=0 and `Iter_Count`+1 = `MAX_ITER` → S10, `Timeout` set, `Iter_Count` increments.
- S8 with `Alu_Neg`=1 also increments `Iter_Count`, so `Iter_Count` always equals the number of S8 visits.
- S9 → S3.
- S10 → S0 when `Ack`=1; otherwise hold. `Iter_Count` and `Timeout` hold their values until the next S2.
- Codes 1011..1111: next state is S0. Outputs still decode from the state register.

Rules:
- `Start` outside S0, `Ack` outside S10, `Div_Ready` outside S3/S5, and `Alu_Neg` outside S8 are ignored.
- `Start` and `Ack` both high in S10: go to S0 only; the host must reassert `Start` in S0.
- Divider stall: the datapath write strobe remains asserted while stalled in S3/S5. The state advances on the same edge that `Div_Ready`=1 is seen, so the last write carries the valid quotient.
- Counter arithmetic is unsigned and does not wrap, because exit at `MAX_ITER` precedes overflow.

## Timing
- Reset values: `Current_State`=0000, `Busy`=0, `Done`=0, `Timeout`=0, `Iter_Count`=0.
- `Reset` asserted in any state, mid-run or mid-stall: S0 on the next edge, all outputs at reset values.
- All outputs are registered state or decoded directly from it. No combinational path runs from inputs to outputs.
- With `Div_Ready` tied high, `Start` sampled high at edge 0 gives S1 at 1, S2 at 2, S3 at 3 and S8 at 8. A converged first pass reaches S10 at edge 9.
- Each extra iteration costs 7 cycles (S9, S3..S8), plus divider stall cycles.
- `Done` falls one cycle after `Ack` is sampled; `Busy` falls on the same edge.

## Structure
- Shared package `sqrt_pkg` holds:
  - state code constants `S0`..`S10`, each 4 bits;
  - ALU op constants (ADD=00, SUB=01, DIV=10, ABS=11);
  - register address constants (n=001, x=010, root=011, temp=100, const2=101, I=110).
- The control decoder imports the same package.
- One sub-module, `iter_counter`, holds `Iter_Count` and `Timeout`:
  - inputs: clear, increment, limit compare;
  - output: `last` flag back to the FSM.

## Test plan
- Reset, then `Start`=1 for one cycle, `Div_Ready`=1, `Alu_Neg`=1 at S8 → `Current_State` runs 1,2,3,4,5,6,7,8,10. `Done`=1 at cycle 9, `Iter_Count`=1, `Timeout`=0. `Ack`=1 → S0 next cycle.
- n=16 flow: `Alu_Neg`=0, 0, then 1 on successive S8 visits → S9 appears twice, S10 is reached with `Iter_Count`=3, total 23 cycles from `Start` to S10.
- `MAX_ITER`=4 with `Alu_Neg` stuck 0 → 3 visits to S9, then S8→S10 with `Timeout`=1 and `Iter_Count`=4.
- Holding `Div_Ready`=0 for 5 cycles in S3 and 3 cycles in S5 → the state holds 0011 for 6 cycles and 0101 for 4 cycles, and S10 arrives 8 cycles later than the no-stall case.
- `Reset` asserted for one cycle while in S5 stall → S0 next edge with all outputs zero. `Start` pulsed while in S4 → ignored, state sequence unchanged.
- In S10, `Start` and `Ack` both high → S0, no new run. Illegal code 1100 forced into the state register → S0 next edge.
